if_id_pipe_reg: RTL and testbench

//  Parametrised IF->ID pipeline register with valid/ready handshake, flush and optional skid buffer.

---
 rtl/core_pkg.sv | 20 ++
 rtl/if_id_pipe_reg_if.sv | 37 +++
 rtl/pipe_skid_buf.sv | 36 +++
 rtl/if_id_pipe_reg.sv | 109 ++++++++++
 tb/tb_if_id_pipe_reg.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module : core_pkg
//  Brief  : Shared core constants: PC/instruction widths, the RV32I canonical
//           NOP (addi x0,x0,0) and the reset PC value.
//  Rev    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    // addi x0, x0, 0
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    // Wide enough for any supported PC width; narrowed at the point of use.
    localparam logic [63:0] RESET_PC = 64'h0;

endpackage
`default_nettype wire

// File: rtl/if_id_pipe_reg_if.sv
`default_nettype none
// ============================================================================
//  Module : if_id_pipe_reg_if
//  Brief  : Fetch->decode handshake bundle for the IF/ID pipeline register.
//           master : fetch/decode side (drives inputs, consumes outputs)
//           slave  : the pipeline register itself
//  Signals: flush_i, in_valid_i, in_ready_o, in_pc_i, in_inst_i,
//           out_valid_o, out_ready_i, out_pc_o, out_inst_o
//  Rev    : 1.0  initial release
// ============================================================================
interface if_id_pipe_reg_if
    import core_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [PC_W-1:0]   in_pc_i;
    logic [INST_W-1:0] in_inst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   out_pc_o;
    logic [INST_W-1:0] out_inst_o;

    modport master (
        output flush_i, in_valid_i, in_pc_i, in_inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_inst_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_pc_i, in_inst_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_inst_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module : pipe_skid_buf
//  Brief  : Single generic skid entry (data + valid). clear has priority over
//           load; data only changes on load (or reset).
//  Ports  : clk, rst   - clock, synchronous active-high reset
//           load, clear- capture d / drop the entry
//           d, q, valid- payload in, held payload, entry occupied
//  Rev    : 1.0  initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module : if_id_pipe_reg
//  Brief  : IF->ID pipeline register with valid/ready handshake, flush and an
//           optional skid entry. SKID=1 gives a registered in_ready (no comb
//           path from decode's ready back to fetch); SKID=0 is a single entry
//           with combinational ready.
//  Ports  : clk, rst - clock, synchronous active-high reset
//           bus      - if_id_pipe_reg_if.slave (flush, in_*, out_*)
//  Rev    : 1.0  initial release
// ============================================================================
module if_id_pipe_reg
    import core_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(RV32I_NOP),
    parameter bit                SKID     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    if_id_pipe_reg_if.slave  bus
);

    localparam int PW = PC_W + INST_W;

    logic              main_valid;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;

    logic              skid_valid;
    logic [PW-1:0]     skid_data;

    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic              main_take;
    logic              skid_load;
    logic              skid_clear;
    logic [PW-1:0]     in_payload;

    assign in_payload = {bus.in_pc_i, bus.in_inst_i};
    assign in_fire    = bus.in_valid_i & in_ready;
    assign out_fire   = main_valid & bus.out_ready_i;

    // Main slot can be (re)written when empty or being consumed this cycle.
    assign main_take  = ~main_valid | out_fire;

    // Input arriving while main is stalled parks in the skid entry; the skid
    // drains into main as soon as main can take it. Flush clears it outright.
    assign skid_load  = in_fire & ~main_take;
    assign skid_clear = bus.flush_i | (main_take & skid_valid);

    generate
        if (SKID) begin : g_skid
            pipe_skid_buf #(
                .WIDTH (PW)
            ) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_payload),
                .q     (skid_data),
                .valid (skid_valid)
            );
            // Registered ready: one free slot is always guaranteed while the
            // skid is empty, so fetch never has to look at decode's ready.
            assign in_ready = ~skid_valid;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign in_ready   = ~main_valid | bus.out_ready_i;
        end
    endgenerate

    // Main entry. The instruction field falls back to NOP whenever the slot
    // empties so decode sees a harmless instruction while out_valid is low;
    // the PC field is left as it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_pc    <= PC_W'(RESET_PC);
            main_inst  <= NOP_INST;
        end else if (bus.flush_i) begin
            main_valid <= 1'b0;
            main_inst  <= NOP_INST;
        end else if (main_take) begin
            if (skid_valid) begin
                main_valid           <= 1'b1;
                {main_pc, main_inst} <= skid_data;
            end else if (in_fire) begin
                main_valid <= 1'b1;
                main_pc    <= bus.in_pc_i;
                main_inst  <= bus.in_inst_i;
            end else begin
                main_valid <= 1'b0;
                main_inst  <= NOP_INST;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = main_valid;
    assign bus.out_pc_o    = main_pc;
    assign bus.out_inst_o  = main_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module : tb_if_id_pipe_reg
//  Brief  : Scoreboard bench for if_id_pipe_reg. Instance A: SKID=1, 32-bit PC.
//           Instance B: SKID=0, 64-bit PC.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_if_id_pipe_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_pipe_reg_if #(.PC_W(32), .INST_W(32)) bus_a ();
    if_id_pipe_reg_if #(.PC_W(64), .INST_W(32)) bus_b ();

    if_id_pipe_reg #(
        .PC_W(32), .INST_W(32), .NOP_INST(32'h0000_0013), .SKID(1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    if_id_pipe_reg #(
        .PC_W(64), .INST_W(32), .NOP_INST(32'h0000_0013), .SKID(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return 32'hA000_0000 ^ pc[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- expectation trackers (at the transfer edge) ----------
    always @(posedge clk) begin
        if (rst || bus_a.flush_i)
            q_a.delete();
        else if (bus_a.in_valid_i && bus_a.in_ready_o)
            q_a.push_back('{64'(bus_a.in_pc_i), bus_a.in_inst_i});
    end

    always @(posedge clk) begin
        if (rst || bus_b.flush_i)
            q_b.delete();
        else if (bus_b.in_valid_i && bus_b.in_ready_o)
            q_b.push_back('{bus_b.in_pc_i, bus_b.in_inst_i});
    end

    // ---------------- monitors (pop on every decode-side transfer) ---------
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_a.out_valid_o && bus_a.out_ready_i) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_entry_pc", 64'(bus_a.out_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                chk("a_out_pc", 64'(bus_a.out_pc_o), e.pc);
                chk("a_out_inst", 64'(bus_a.out_inst_o), 64'(e.inst));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_b.out_valid_o && bus_b.out_ready_i) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_entry_inst", 64'(bus_b.out_inst_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                chk("b_out_pc", bus_b.out_pc_o, e.pc);
                chk("b_out_inst", 64'(bus_b.out_inst_o), 64'(e.inst));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_a(input logic [31:0] pc);
        bus_a.in_valid_i = 1'b1;
        bus_a.in_pc_i    = pc;
        bus_a.in_inst_i  = inst_of(64'(pc));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] pcb;
        rst = 1'b1;
        bus_a.flush_i = 1'b0; bus_a.in_valid_i = 1'b0; bus_a.in_pc_i = '0;
        bus_a.in_inst_i = '0; bus_a.out_ready_i = 1'b0;
        bus_b.flush_i = 1'b0; bus_b.in_valid_i = 1'b0; bus_b.in_pc_i = '0;
        bus_b.in_inst_i = '0; bus_b.out_ready_i = 1'b0;

        // 1: reset state
        step(); step();
        chk("a_rst_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("a_rst_inst",  64'(bus_a.out_inst_o),  64'h13);
        chk("a_rst_pc",    64'(bus_a.out_pc_o),    64'h0);
        chk("a_rst_ready", 64'(bus_a.in_ready_o),  64'd1);
        chk("b_rst_valid", 64'(bus_b.out_valid_o), 64'd0);
        chk("b_rst_inst",  64'(bus_b.out_inst_o),  64'h13);
        chk("b_rst_pc",    bus_b.out_pc_o,         64'h0);
        chk("b_rst_ready", 64'(bus_b.in_ready_o),  64'd1);
        rst = 1'b0;
        step();

        // 2: back-to-back stream with decode always ready
        bus_a.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_a(32'(i * 4));
            step();
            chk("a_stream_valid", 64'(bus_a.out_valid_o), 64'd1);
            chk("a_stream_pc",    64'(bus_a.out_pc_o),    64'(i * 4));
        end
        bus_a.in_valid_i = 1'b0;
        step();
        chk("a_stream_drained", 64'(bus_a.out_valid_o), 64'd0);
        chk("a_stream_nop",     64'(bus_a.out_inst_o),  64'h13);

        // 3: stall fills the skid, release drains in order
        bus_a.out_ready_i = 1'b0;
        send_a(32'h10); step();
        chk("a_stall_ready1", 64'(bus_a.in_ready_o), 64'd1);
        chk("a_stall_pc1",    64'(bus_a.out_pc_o),   64'h10);
        send_a(32'h14); step();
        chk("a_stall_ready2", 64'(bus_a.in_ready_o), 64'd0);
        chk("a_stall_pc2",    64'(bus_a.out_pc_o),   64'h10);
        bus_a.in_valid_i = 1'b0; step();
        chk("a_stall_hold_pc",   64'(bus_a.out_pc_o),   64'h10);
        chk("a_stall_hold_inst", 64'(bus_a.out_inst_o), 64'(inst_of(64'h10)));
        bus_a.out_ready_i = 1'b1; step();
        chk("a_release_pc",    64'(bus_a.out_pc_o),   64'h14);
        chk("a_release_ready", 64'(bus_a.in_ready_o), 64'd1);
        step();
        chk("a_release_empty", 64'(bus_a.out_valid_o), 64'd0);

        // 4: flush with skid full
        bus_a.out_ready_i = 1'b0;
        send_a(32'h20); step();
        send_a(32'h24); step();
        bus_a.in_valid_i = 1'b0;
        chk("a_full_ready", 64'(bus_a.in_ready_o), 64'd0);
        bus_a.flush_i = 1'b1; step();
        bus_a.flush_i = 1'b0;
        chk("a_flush_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("a_flush_inst",  64'(bus_a.out_inst_o),  64'h13);
        chk("a_flush_ready", 64'(bus_a.in_ready_o),  64'd1);
        chk("a_flush_pc",    64'(bus_a.out_pc_o),    64'h20);
        bus_a.out_ready_i = 1'b1; step();
        chk("a_flush_no_skid", 64'(bus_a.out_valid_o), 64'd0);

        // 5: flush in the same cycle as an input transfer
        send_a(32'h30); bus_a.flush_i = 1'b1; step();
        bus_a.flush_i = 1'b0; bus_a.in_valid_i = 1'b0;
        chk("a_flush_in_valid", 64'(bus_a.out_valid_o), 64'd0);
        step();
        chk("a_flush_in_valid2", 64'(bus_a.out_valid_o), 64'd0);
        send_a(32'h34); step();
        chk("a_after_flush_pc", 64'(bus_a.out_pc_o), 64'h34);
        send_a(32'h40); step();
        chk("a_pre_flush_pc", 64'(bus_a.out_pc_o), 64'h40);
        // flush while decode consumes 0x40: consume stands, new 0x44 dropped
        send_a(32'h44); bus_a.flush_i = 1'b1; step();
        bus_a.flush_i = 1'b0; bus_a.in_valid_i = 1'b0;
        chk("a_flush_fire_valid", 64'(bus_a.out_valid_o), 64'd0);

        // reset during a full stall
        bus_a.out_ready_i = 1'b0;
        send_a(32'h50); step();
        send_a(32'h54); step();
        bus_a.in_valid_i = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0;
        chk("a_midrst_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("a_midrst_pc",    64'(bus_a.out_pc_o),    64'h0);
        chk("a_midrst_ready", 64'(bus_a.in_ready_o),  64'd1);
        bus_a.out_ready_i = 1'b1; step();
        chk("a_midrst_empty", 64'(bus_a.out_valid_o), 64'd0);

        // 6: SKID=0, combinational ready
        bus_b.out_ready_i = 1'b0;
        bus_b.in_valid_i  = 1'b1;
        bus_b.in_pc_i     = 64'h8000_0000_0000_0100;
        bus_b.in_inst_i   = inst_of(64'h8000_0000_0000_0100);
        step();
        bus_b.in_valid_i = 1'b0;
        chk("b_comb_ready_lo", 64'(bus_b.in_ready_o), 64'd0);
        chk("b_wide_pc",       bus_b.out_pc_o,        64'h8000_0000_0000_0100);
        bus_b.out_ready_i = 1'b1;
        #1;
        chk("b_comb_ready_hi", 64'(bus_b.in_ready_o), 64'd1);
        step();

        // random valid/ready/flush traffic on both instances
        for (int i = 0; i < 300; i++) begin
            pcb = 64'hFFFF_FFFF_0000_0000 + 64'(i * 4);
            bus_a.in_valid_i  = 1'($urandom_range(0, 1));
            bus_a.in_pc_i     = 32'h1000 + 32'(i * 4);
            bus_a.in_inst_i   = inst_of(64'(bus_a.in_pc_i));
            bus_a.out_ready_i = ($urandom_range(0, 2) != 0);
            bus_a.flush_i     = ($urandom_range(0, 15) == 0);
            bus_b.in_valid_i  = 1'($urandom_range(0, 1));
            bus_b.in_pc_i     = pcb;
            bus_b.in_inst_i   = inst_of(pcb);
            bus_b.out_ready_i = ($urandom_range(0, 2) != 0);
            bus_b.flush_i     = ($urandom_range(0, 15) == 0);
            step();
        end

        // drain and confirm nothing was lost
        bus_a.in_valid_i = 1'b0; bus_a.flush_i = 1'b0; bus_a.out_ready_i = 1'b1;
        bus_b.in_valid_i = 1'b0; bus_b.flush_i = 1'b0; bus_b.out_ready_i = 1'b1;
        repeat (4) step();
        chk("a_scoreboard_left", 64'(q_a.size()), 64'd0);
        chk("b_scoreboard_left", 64'(q_b.size()), 64'd0);
        chk("a_final_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("b_final_valid", 64'(bus_b.out_valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
